// File: rtl/line_memory_pkg.sv
// Shared defaults and FSM state encoding for the line memory.
package line_memory_pkg;

  localparam int LINE_W_DEF  = 256;
  localparam int DEPTH_DEF   = 512;
  localparam int LATENCY_DEF = 10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/line_memory_array.sv
// Line storage with byte-masked synchronous write and registered read, no reset.
// Read data updates only on re; a write and a read are never issued in the same cycle.
module line_memory_array #(
  parameter int LINE_W = 256,
  parameter int DEPTH  = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [LINE_W-1:0]        wdata,
  input  logic [LINE_W/8-1:0]      wmask,
  output logic [LINE_W-1:0]        rdata
);

  localparam int NB = LINE_W / 8;

  logic [LINE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/line_memory.sv
// Fixed-latency line memory: one request at a time, ack LATENCY edges after acceptance.
// req_i is dropped (not queued) while busy_o is high; LINE_MEMORY_WMASK_EN enables byte masks.
module line_memory
  import line_memory_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [31:0]         addr_i,
  input  logic [LINE_W-1:0]   wdata_i,
  input  logic [LINE_W/8-1:0] wmask_i,
  output logic                busy_o,
  output logic                ack_o,
  output logic                err_o,
  output logic [LINE_W-1:0]   rdata_o
);

  localparam int NB  = LINE_W / 8;
  localparam int OFS = $clog2(NB);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(LATENCY + 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              accept, done;
  logic [31:0]       line_idx;
  logic              req_we, req_err;
  logic [AW-1:0]     req_idx;
  logic [LINE_W-1:0] req_wdata;
  logic [NB-1:0]     wmask_eff;
  logic              rd_zero;
  logic [LINE_W-1:0] arr_rdata;

  assign line_idx = addr_i >> OFS;
  assign busy_o   = (state == WAIT);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (req_i) begin
        accept    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (cnt == CW'(LATENCY - 1)) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // counts edges since acceptance; the completing edge clears it
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                    cnt <= '0;
    else if (state == WAIT && !done) cnt <= cnt + CW'(1);
    else                           cnt <= '0;
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      req_we    <= we_i;
      req_idx   <= line_idx[AW-1:0];
      req_err   <= (line_idx >= 32'(DEPTH));
      req_wdata <= wdata_i;
    end
  end

`ifdef LINE_MEMORY_WMASK_EN
  logic [NB-1:0] req_wmask;

  always_ff @(posedge clk_i) begin
    if (accept) req_wmask <= wmask_i;
  end

  assign wmask_eff = req_wmask;
`else
  logic unused_wmask;

  assign unused_wmask = ^wmask_i;
  assign wmask_eff    = '1;
`endif

  // rdata_o is the array register gated by rd_zero, so reset and error reads show zero
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      ack_o <= done;
      err_o <= done & req_err;
      if (done && !req_we) rd_zero <= req_err;
    end
  end

  assign rdata_o = rd_zero ? '0 : arr_rdata;

  line_memory_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk_i),
    .we    (done & req_we & ~req_err),
    .re    (done & ~req_we & ~req_err),
    .addr  (req_idx),
    .wdata (req_wdata),
    .wmask (wmask_eff),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory with a transaction-level reference model.
module tb_line_memory;

  localparam int LW  = 256;
  localparam int DP  = 512;
  localparam int LAT = 10;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_i, we_i;
  logic [31:0]   addr_i;
  logic [LW-1:0] wdata_i;
  logic [31:0]   wmask_i;
  logic          busy_o, ack_o, err_o;
  logic [LW-1:0] rdata_o;

  int errors = 0;
  int checks = 0;

  line_memory #(.LINE_W(LW), .DEPTH(DP), .LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .wmask_i(wmask_i), .busy_o(busy_o), .ack_o(ack_o),
    .err_o(err_o), .rdata_o(rdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction, completion due LAT edges after acceptance.
  logic [LW-1:0] m_mem [DP];
  logic [LW-1:0] m_rdata;
  bit            m_busy, m_ack, m_err;
  int            n_edge, due;
  bit            q_we, q_err;
  int            q_idx;
  logic [LW-1:0] q_wd;
  logic [31:0]   q_wm;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_busy = 0; m_ack = 0; m_err = 0; m_rdata = '0; n_edge = 0; due = 0;
    end else begin
      n_edge++;
      m_ack = 0;
      m_err = 0;
      if (m_busy) begin
        if (n_edge == due) begin
          m_busy = 0;
          m_ack  = 1;
          m_err  = q_err;
          if (q_err) begin
            if (!q_we) m_rdata = '0;
          end else if (q_we) begin
            for (int b = 0; b < LW / 8; b++) begin
`ifdef LINE_MEMORY_WMASK_EN
              if (q_wm[b]) m_mem[q_idx][b*8 +: 8] = q_wd[b*8 +: 8];
`else
              m_mem[q_idx][b*8 +: 8] = q_wd[b*8 +: 8];
`endif
            end
          end else begin
            m_rdata = m_mem[q_idx];
          end
        end
      end else if (req_i) begin
        m_busy = 1;
        due    = n_edge + LAT;
        q_we   = we_i;
        q_err  = (addr_i / 32) >= DP;
        q_idx  = int'(addr_i / 32) % DP;
        q_wd   = wdata_i;
        q_wm   = wmask_i;
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_i === 1'b1) begin
      chk("cyc_busy",  LW'(busy_o), LW'(m_busy));
      chk("cyc_ack",   LW'(ack_o),  LW'(m_ack));
      chk("cyc_err",   LW'(err_o),  LW'(m_err));
      chk("cyc_rdata", rdata_o,     m_rdata);
    end
  end

  // Issue one request from a negedge; returns at the negedge of the ack cycle.
  task automatic run_req(input bit we, input logic [31:0] addr, input logic [LW-1:0] wd,
                         input logic [31:0] wm, output int lat, output int bcnt);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd; wmask_i = wm;
    @(negedge clk_i);
    req_i = 1'b0; we_i = ~we; addr_i = 32'hFFFF_FFE0; wdata_i = ~wd; wmask_i = ~wm;
    bcnt = busy_o ? 1 : 0;
    lat  = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      if (ack_o) begin
        lat = k;
        break;
      end
      if (busy_o) bcnt++;
    end
  endtask

  logic [LW-1:0] pat_a5, pat_3c, pat_5a, pat_11, ones, exp_mask;
  int lat, bcnt, ackc, k1, k2;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_3c = {32{8'h3C}};
    pat_5a = {32{8'h5A}};
    pat_11 = {32{8'h11}};
    ones   = '1;
`ifdef LINE_MEMORY_WMASK_EN
    exp_mask = {{28{8'hA5}}, 32'h0};
`else
    exp_mask = '0;
`endif
    rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; wmask_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy",  LW'(busy_o), '0);
    chk("rst_ack",   LW'(ack_o),  '0);
    chk("rst_err",   LW'(err_o),  '0);
    chk("rst_rdata", rdata_o,     '0);
    rst_i = 1'b1;
    @(negedge clk_i);

    run_req(1'b1, 32'h0,  pat_3c, '1, lat, bcnt);
    chk("wr0_lat", LW'(lat), LW'(LAT));
    run_req(1'b1, 32'h80, pat_5a, '1, lat, bcnt);
    run_req(1'b1, 32'h40, pat_a5, '1, lat, bcnt);
    chk("wr40_lat",  LW'(lat),  LW'(LAT));
    chk("wr40_busy", LW'(bcnt), LW'(LAT));
    chk("wr40_err",  LW'(err_o), '0);
    run_req(1'b0, 32'h40, '0, '0, lat, bcnt);
    chk("rd40_lat",   LW'(lat),  LW'(LAT));
    chk("rd40_busy",  LW'(bcnt), LW'(LAT));
    chk("rd40_rdata", rdata_o,   pat_a5);

    run_req(1'b1, 32'h40, '0, 32'h0000_000F, lat, bcnt);
    run_req(1'b0, 32'h40, '0, '0, lat, bcnt);
    chk("mask_rdata", rdata_o, exp_mask);

    // second request while busy is dropped
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h40;
    @(negedge clk_i);
    req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h40; wdata_i = ones; wmask_i = '1;
    @(negedge clk_i);
    req_i = 1'b0;
    ackc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (ack_o) ackc++;
    end
    chk("busy_ign_acks", LW'(ackc), LW'(1));
    run_req(1'b0, 32'h40, '0, '0, lat, bcnt);
    chk("busy_ign_data", rdata_o, exp_mask);

    // req held through the ack cycle: accept at 0 and 11, acks at 10 and 21
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0;
    k1 = -1; k2 = -1;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk_i);
      if (ack_o) begin
        if (k1 < 0) k1 = k;
        else if (k2 < 0) k2 = k;
      end
      if (k == 11) begin
        chk("b2b_accept11", LW'(busy_o), LW'(1));
        req_i = 1'b0;
      end
    end
    chk("b2b_ack1", LW'(k1), LW'(10));
    chk("b2b_ack2", LW'(k2), LW'(21));

    run_req(1'b0, 32'h4000, '0, '0, lat, bcnt);
    chk("oor_lat",   LW'(lat),   LW'(LAT));
    chk("oor_err",   LW'(err_o), LW'(1));
    chk("oor_rdata", rdata_o,    '0);
    run_req(1'b1, 32'h4000, ones, '1, lat, bcnt);
    chk("oor_wr_err", LW'(err_o), LW'(1));
    run_req(1'b0, 32'h0, '0, '0, lat, bcnt);
    chk("rd0_err",   LW'(err_o), '0);
    chk("rd0_rdata", rdata_o,    pat_3c);

    // reset at edge 5 of a write aborts it
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h80; wdata_i = pat_11; wmask_i = '1;
    @(negedge clk_i);
    req_i = 1'b0;
    repeat (4) @(negedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    chk("abort_busy",  LW'(busy_o), '0);
    chk("abort_ack",   LW'(ack_o),  '0);
    chk("abort_err",   LW'(err_o),  '0);
    chk("abort_rdata", rdata_o,     '0);
    @(negedge clk_i);
    rst_i = 1'b1;
    ackc = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk_i);
      if (ack_o) ackc++;
    end
    chk("abort_no_ack", LW'(ackc), '0);
    run_req(1'b0, 32'h80, '0, '0, lat, bcnt);
    chk("abort_rd80", rdata_o, pat_5a);

    repeat (2) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
